// File: rtl/acc_cpu_param_if.sv
// Command/status bundle for acc_cpu_param: host-side command inputs,
// core-side status outputs and the FSM state for observation.
interface acc_cpu_param_if #(
  parameter int WIDTH = 8,
  parameter int NREGS = 8
);
  localparam int SELW = $clog2(NREGS);

  logic [WIDTH-1:0] data_in;
  logic [SELW-1:0]  sel;
  logic [3:0]       op;
  logic             cin;
  logic             load;
  logic             ce;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] data_out;
  logic [3:0]       flags;
  logic [1:0]       state;

  modport master (
    output data_in, sel, op, cin, load, ce,
    input  busy, done, data_out, flags, state
  );

  modport slave (
    input  data_in, sel, op, cin, load, ce,
    output busy, done, data_out, flags, state
  );
endinterface

// File: rtl/acc_cpu_param.sv
// Parametrised accumulator core: NREGS x WIDTH register file, R0 as the
// accumulator, three-state EXEC/WB sequence and registered {N,V,Z,C} flags.
module acc_cpu_param #(
  parameter int WIDTH = 8,
  parameter int NREGS = 8
) (
  input logic           clk,
  input logic           rst,
  acc_cpu_param_if.slave bus
);
  localparam int SELW = $clog2(NREGS);
  localparam int MSB  = WIDTH - 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_ADC = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_SBB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_ASR = 4'd10;
  localparam logic [3:0] OP_MOV = 4'd11;
  localparam logic [3:0] OP_INC = 4'd12;
  localparam logic [3:0] OP_DEC = 4'd13;
  localparam logic [3:0] OP_CMP = 4'd14;
  localparam logic [3:0] OP_NOP = 4'd15;

  localparam logic [WIDTH:0] ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] regs [NREGS];
  logic [3:0]       op_q;
  logic [SELW-1:0]  sel_q;
  logic             cin_q;
  logic [WIDTH-1:0] res_q;
  logic [3:0]       flg_h;
  logic [3:0]       flags_q;
  logic             done_q;

  // Handshake: a command is taken when ce=1 in IDLE. load=1 writes R[sel]
  // immediately; load=0 starts an ALU op, busy covers EXEC and WB, and done
  // pulses for one cycle after write-back. ce while busy is dropped.
  logic load_fire, cmd_fire, wb_r0, wb_flags;

  assign load_fire = (state == IDLE) && bus.ce && bus.load;
  assign cmd_fire  = (state == IDLE) && bus.ce && !bus.load;
  assign wb_r0     = (state == WB) && (op_q != OP_CMP) && (op_q != OP_NOP);
  assign wb_flags  = (state == WB) && (op_q != OP_NOP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_fire) state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ALU: operands are read only while the latched command sits in EXEC.
  logic [WIDTH-1:0] a, b, res;
  logic [WIDTH:0]   ext;
  logic             c_f, v_f;

  assign a = regs[0];
  assign b = regs[sel_q];

  always_comb begin
    ext = '0;
    res = '0;
    c_f = 1'b0;
    v_f = 1'b0;
    case (op_q)
      OP_ADD, OP_ADC: begin
        ext = {1'b0, a} + {1'b0, b} +
              ((op_q == OP_ADC) ? {{WIDTH{1'b0}}, cin_q} : '0);
        res = ext[MSB:0];
        c_f = ext[WIDTH];
        v_f = ~(a[MSB] ^ b[MSB]) & (res[MSB] ^ a[MSB]);
      end
      OP_SUB, OP_SBB, OP_CMP: begin
        ext = {1'b0, a} - {1'b0, b} -
              ((op_q == OP_SBB) ? {{WIDTH{1'b0}}, cin_q} : '0);
        res = ext[MSB:0];
        c_f = ext[WIDTH];
        v_f = (a[MSB] ^ b[MSB]) & (res[MSB] ^ a[MSB]);
      end
      OP_INC: begin
        ext = {1'b0, a} + ONE_EXT;
        res = ext[MSB:0];
        c_f = ext[WIDTH];
        v_f = ~a[MSB] & res[MSB];
      end
      OP_DEC: begin
        ext = {1'b0, a} - ONE_EXT;
        res = ext[MSB:0];
        c_f = ext[WIDTH];
        v_f = a[MSB] & ~res[MSB];
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOT: res = ~a;
      OP_SHL: begin
        res = {a[MSB-1:0], 1'b0};
        c_f = a[MSB];
      end
      OP_SHR: begin
        res = {1'b0, a[MSB:1]};
        c_f = a[0];
      end
      OP_ASR: begin
        res = {a[MSB], a[MSB:1]};
        c_f = a[0];
      end
      OP_MOV:  res = b;
      default: res = a;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q  <= '0;
      sel_q <= '0;
      cin_q <= 1'b0;
    end else if (cmd_fire) begin
      op_q  <= bus.op;
      sel_q <= bus.sel;
      cin_q <= bus.cin;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_q <= '0;
      flg_h <= '0;
    end else if (state == EXEC) begin
      res_q <= res;
      flg_h <= {res[MSB], v_f, (res == '0), c_f};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (load_fire) begin
      regs[bus.sel] <= bus.data_in;
    end else if (wb_r0) begin
      regs[0] <= res_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags_q <= '0;
      done_q  <= 1'b0;
    end else begin
      if (wb_flags) flags_q <= flg_h;
      done_q <= (state == WB);
    end
  end

  assign bus.busy     = (state == EXEC) || (state == WB);
  assign bus.done     = done_q;
  assign bus.data_out = regs[0];
  assign bus.flags    = flags_q;
  assign bus.state    = state;
endmodule

// File: tb/tb_acc_cpu_param.sv
// Directed bench for acc_cpu_param: an 8-bit/8-register core and a
// 16-bit/32-register core sharing clock and reset.
module tb_acc_cpu_param;
  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  acc_cpu_param_if #(.WIDTH(8),  .NREGS(8))  bus8 ();
  acc_cpu_param_if #(.WIDTH(16), .NREGS(32)) bus16 ();

  acc_cpu_param #(.WIDTH(8), .NREGS(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  acc_cpu_param #(.WIDTH(16), .NREGS(32)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // drivers
  task automatic load8(input logic [2:0] s, input logic [7:0] d);
    @(negedge clk);
    bus8.ce = 1'b1; bus8.load = 1'b1; bus8.sel = s; bus8.data_in = d;
    @(posedge clk); #1;
    bus8.ce = 1'b0; bus8.load = 1'b0;
  endtask

  // Samples busy/done at the three negedges after the accept edge k.
  task automatic alu8(input logic [3:0] o, input logic [2:0] s, input logic c,
                      input bit no_wait,
                      output logic [2:0] bseq, output logic [2:0] dseq);
    if (!no_wait) @(negedge clk);
    bus8.ce = 1'b1; bus8.load = 1'b0; bus8.op = o; bus8.sel = s; bus8.cin = c;
    @(posedge clk); #1;
    bus8.ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bseq[i] = bus8.busy;
      dseq[i] = bus8.done;
    end
  endtask

  task automatic load16(input logic [4:0] s, input logic [15:0] d);
    @(negedge clk);
    bus16.ce = 1'b1; bus16.load = 1'b1; bus16.sel = s; bus16.data_in = d;
    @(posedge clk); #1;
    bus16.ce = 1'b0; bus16.load = 1'b0;
  endtask

  task automatic alu16(input logic [3:0] o, input logic [4:0] s);
    @(negedge clk);
    bus16.ce = 1'b1; bus16.load = 1'b0; bus16.op = o; bus16.sel = s; bus16.cin = 1'b0;
    @(posedge clk); #1;
    bus16.ce = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // scenarios
  task automatic test_reset();
    logic [2:0] bs, ds;
    if ({bus8.busy, bus8.done, bus8.data_out, bus8.flags} !== 14'd0) begin
      failures++;
      $display("FAIL reset_init: got busy=%b done=%b data=%h flags=%b, want all 0",
               bus8.busy, bus8.done, bus8.data_out, bus8.flags);
    end
    checks++;
    load8(3'd0, 8'h55);
    @(negedge clk);
    if (bus8.data_out !== 8'h55) begin
      failures++; $display("FAIL reset_preload: got %h want 55", bus8.data_out);
    end
    checks++;
    bus8.ce = 1'b1; bus8.load = 1'b0; bus8.op = 4'd0; bus8.sel = 3'd0; bus8.cin = 1'b0;
    @(posedge clk); #1;
    bus8.ce = 1'b0;
    #2 rst = 1'b0;
    #1;
    if ({bus8.busy, bus8.done, bus8.data_out, bus8.flags, bus8.state} !== 16'd0) begin
      failures++;
      $display("FAIL reset_mid_exec: got busy=%b done=%b data=%h flags=%b state=%0d, want all 0",
               bus8.busy, bus8.done, bus8.data_out, bus8.flags, bus8.state);
    end
    checks++;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      alu8(4'd11, i[2:0], 1'b0, 1'b0, bs, ds);
      if (bus8.data_out !== 8'h00 || bus8.flags !== 4'b0010) begin
        failures++;
        $display("FAIL reset_reg%0d: got data=%h flags=%b want 00 0010",
                 i, bus8.data_out, bus8.flags);
      end
      checks++;
    end
  endtask

  task automatic test_add_carry();
    logic [2:0] bs, ds;
    load8(3'd0, 8'hF0);
    load8(3'd3, 8'h20);
    alu8(4'd0, 3'd3, 1'b0, 1'b0, bs, ds);
    if (bs !== 3'b011 || ds !== 3'b100) begin
      failures++; $display("FAIL add_timing: got busy=%b done=%b want 011 100", bs, ds);
    end
    checks++;
    if (bus8.data_out !== 8'h10 || bus8.flags !== 4'b0001) begin
      failures++;
      $display("FAIL add_carry: got data=%h flags=%b want 10 0001", bus8.data_out, bus8.flags);
    end
    checks++;
    @(negedge clk);
    if (bus8.done !== 1'b0) begin
      failures++; $display("FAIL done_pulse_width: got done=%b want 0", bus8.done);
    end
    checks++;
  endtask

  task automatic test_sub_overflow();
    logic [2:0] bs, ds;
    load8(3'd0, 8'h80);
    load8(3'd1, 8'h01);
    alu8(4'd2, 3'd1, 1'b0, 1'b0, bs, ds);
    if (bus8.data_out !== 8'h7F || bus8.flags !== 4'b0100) begin
      failures++;
      $display("FAIL sub_ovf: got data=%h flags=%b want 7f 0100", bus8.data_out, bus8.flags);
    end
    checks++;
    load8(3'd1, 8'h7F);
    alu8(4'd3, 3'd1, 1'b1, 1'b0, bs, ds);
    if (bus8.data_out !== 8'hFF || bus8.flags !== 4'b1001) begin
      failures++;
      $display("FAIL sbb_borrow: got data=%h flags=%b want ff 1001", bus8.data_out, bus8.flags);
    end
    checks++;
  endtask

  task automatic test_cmp_nop();
    logic [2:0] bs, ds;
    logic [7:0] d_exp [4] = '{8'h42, 8'h42, 8'h42, 8'h42};
    logic [3:0] f_exp [4] = '{4'b0010, 4'b0010, 4'b1001, 4'b1001};
    logic [3:0] o_tab [4] = '{4'd14, 4'd15, 4'd14, 4'd15};
    load8(3'd0, 8'h42);
    load8(3'd2, 8'h42);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) load8(3'd2, 8'h43);
      alu8(o_tab[i], 3'd2, 1'b0, 1'b0, bs, ds);
      if (bus8.data_out !== d_exp[i] || bus8.flags !== f_exp[i] || ds !== 3'b100) begin
        failures++;
        $display("FAIL cmp_nop_%0d: got data=%h flags=%b done=%b want %h %b 100",
                 i, bus8.data_out, bus8.flags, ds, d_exp[i], f_exp[i]);
      end
      checks++;
    end
  endtask

  task automatic test_ops();
    logic [2:0] bs, ds;
    logic [3:0] o_tab [10] = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd12, 4'd13, 4'd9, 4'd12, 4'd1, 4'd0};
    logic [2:0] s_tab [10] = '{3'd4, 3'd4, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd4, 3'd0};
    logic       c_tab [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] d_exp [10] = '{8'h03, 8'h0F, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h7F, 8'h80, 8'h90, 8'h20};
    logic [3:0] f_exp [10] = '{4'b0000, 4'b0000, 4'b0010, 4'b1000, 4'b0011,
                               4'b1001, 4'b0001, 4'b1100, 4'b1000, 4'b0101};
    load8(3'd0, 8'hC3);
    load8(3'd4, 8'h0F);
    for (int i = 0; i < 10; i++) begin
      alu8(o_tab[i], s_tab[i], c_tab[i], 1'b0, bs, ds);
      if (bus8.data_out !== d_exp[i] || bus8.flags !== f_exp[i]) begin
        failures++;
        $display("FAIL op_%0d: got data=%h flags=%b want %h %b",
                 o_tab[i], bus8.data_out, bus8.flags, d_exp[i], f_exp[i]);
      end
      checks++;
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] bs, ds;
    load8(3'd5, 8'h11);
    load8(3'd0, 8'h03);
    @(negedge clk);
    bus8.ce = 1'b1; bus8.load = 1'b0; bus8.op = 4'd0; bus8.sel = 3'd5; bus8.cin = 1'b0;
    @(posedge clk); #1;
    bus8.load = 1'b1; bus8.sel = 3'd5; bus8.data_in = 8'hAA;
    @(posedge clk); #1;
    bus8.ce = 1'b0; bus8.load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if (bus8.done !== 1'b1 || bus8.data_out !== 8'h14) begin
      failures++;
      $display("FAIL busy_add: got done=%b data=%h want 1 14", bus8.done, bus8.data_out);
    end
    checks++;
    alu8(4'd11, 3'd5, 1'b0, 1'b1, bs, ds);
    if (bs !== 3'b011 || ds !== 3'b100) begin
      failures++; $display("FAIL b2b_accept: got busy=%b done=%b want 011 100", bs, ds);
    end
    checks++;
    if (bus8.data_out !== 8'h11) begin
      failures++; $display("FAIL busy_drop_load: got R5=%h want 11", bus8.data_out);
    end
    checks++;
  endtask

  task automatic test_param_sweep();
    load16(5'd31, 16'h8001);
    load16(5'd0, 16'h8001);
    alu16(4'd8, 5'd0);
    if (bus16.data_out !== 16'h0002 || bus16.flags !== 4'b0001) begin
      failures++;
      $display("FAIL w16_shl: got data=%h flags=%b want 0002 0001", bus16.data_out, bus16.flags);
    end
    checks++;
    load16(5'd0, 16'h8000);
    alu16(4'd10, 5'd0);
    if (bus16.data_out !== 16'hC000 || bus16.flags !== 4'b1000) begin
      failures++;
      $display("FAIL w16_asr: got data=%h flags=%b want c000 1000", bus16.data_out, bus16.flags);
    end
    checks++;
    alu16(4'd11, 5'd31);
    if (bus16.data_out !== 16'h8001 || bus16.flags !== 4'b1000) begin
      failures++;
      $display("FAIL w16_mov31: got data=%h flags=%b want 8001 1000", bus16.data_out, bus16.flags);
    end
    checks++;
  endtask

  initial begin
    rst = 1'b0;
    bus8.ce = 1'b0;  bus8.load = 1'b0;  bus8.op = '0;  bus8.sel = '0;
    bus8.cin = 1'b0; bus8.data_in = '0;
    bus16.ce = 1'b0; bus16.load = 1'b0; bus16.op = '0; bus16.sel = '0;
    bus16.cin = 1'b0; bus16.data_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    test_reset();
    test_add_carry();
    test_sub_overflow();
    test_cmp_nop();
    test_ops();
    test_back_to_back();
    test_param_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
